// File: rtl/dmem_write_queue.sv
// Write queue between the store buffer and data memory: holds committed stores,
// drains them in order over a valid/ready port, coalesces and forwards to loads.
module dmem_write_queue #(
  parameter int WORD_SIZE_P = 16,
  parameter int WQ_ENTRY    = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   sb_mem_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
  output logic                   wq_full_o,
  output logic                   wq_empty_o,
  output logic                   wq_overflow_o,
  input  logic                   ld_v_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   wq_ld_hit_o,
  output logic [WORD_SIZE_P-1:0] wq_ld_data_o,
  output logic                   mem_w_v_o,
  output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_w_data_o,
  input  logic                   mem_w_ready_i
);

  localparam int PTR_W = (WQ_ENTRY > 1) ? $clog2(WQ_ENTRY) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WQ_ENTRY);

  logic [WQ_ENTRY-1:0]    valid_q;
  logic [WORD_SIZE_P-1:0] addr_q [WQ_ENTRY];
  logic [WORD_SIZE_P-1:0] data_q [WQ_ENTRY];
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_n;
  logic                   overflow_q;

  logic [PTR_W-1:0]       tail_m1;
  logic                   deq;
  logic                   coalesce;
  logic                   enq;
  logic                   drop;
  logic                   fwd_hit;
  logic [WORD_SIZE_P-1:0] fwd_data;

  assign wq_full_o     = (count_q == CNT_FULL);
  assign wq_empty_o    = (count_q == '0);
  assign wq_overflow_o = overflow_q;

  assign mem_w_v_o    = ~wq_empty_o;
  assign mem_w_addr_o = addr_q[head_q];
  assign mem_w_data_o = data_q[head_q];

  // Coalescing needs two entries so the head (possibly mid-write) is never modified.
  assign tail_m1  = tail_q - PTR_W'(1);
  assign deq      = mem_w_v_o & mem_w_ready_i;
  assign coalesce = sb_mem_v_i & (count_q >= CNT_W'(2)) & (addr_q[tail_m1] == sb_mem_addr_i);
  assign enq      = sb_mem_v_i & ~coalesce & ~wq_full_o;
  assign drop     = sb_mem_v_i & ~coalesce & wq_full_o;

  always_comb begin
    count_n = count_q;
    if (enq && !deq)      count_n = count_q + CNT_W'(1);
    else if (!enq && deq) count_n = count_q - CNT_W'(1);
  end

  // Walk oldest to youngest so the youngest matching entry is the last writer.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WQ_ENTRY; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == ld_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  assign wq_ld_hit_o  = ld_v_i & fwd_hit;
  assign wq_ld_data_o = wq_ld_hit_o ? fwd_data : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_n;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by valid_q/count_q.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail_q] <= sb_mem_addr_i;
      data_q[tail_q] <= sb_mem_data_i;
    end else if (coalesce) begin
      data_q[tail_m1] <= sb_mem_data_i;
    end
  end

endmodule
